snake_motion_engine: RTL and testbench

SNAKE_MOTION_ENGINE -- requirements
Module: snake_motion_engine

---
 rtl/snake_motion_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_snake_motion_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_motion_engine.sv
// snake_motion_engine
// Snake game motion core: IDLE/RUN/DEAD control, step prescaler, heading
// filter, segment shift buffer, grow handling and collision detection.
// Optional build macro: SNAKE_WRAP_EN -- when defined, the head wraps around
// the playfield edges instead of dying on a wall.
module snake_motion_engine #(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int MOVE_DIV = 5000000,
  parameter int MAX_LEN  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  direction,
  input  logic        start,
  input  logic        grow,
  input  logic [3:0]  seg_sel,
  output logic [10:0] head_x,
  output logic [10:0] head_y,
  output logic [10:0] seg_x,
  output logic [10:0] seg_y,
  output logic [4:0]  length,
  output logic        move_strobe,
  output logic        game_over,
  output logic [1:0]  state
);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int          PW         = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(MOVE_DIV - 1);
  localparam logic [10:0] X_MAX      = 11'(GRID_W - 1);
  localparam logic [10:0] Y_MAX      = 11'(GRID_H - 1);
  localparam logic [10:0] X_CENTER   = 11'(GRID_W / 2);
  localparam logic [10:0] Y_CENTER   = 11'(GRID_H / 2);
  localparam logic [4:0]  LEN_MAX    = 5'(MAX_LEN);
  localparam logic [4:0]  LEN_INIT   = 5'd3;
  localparam logic [1:0]  HEAD_INIT  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  state_t            state_reg, state_next;
  logic [PW-1:0]     presc_reg;
  logic [1:0]        heading_reg;
  logic              grow_pend_reg;
  logic [4:0]        length_reg;
  logic              move_strobe_reg;

  // Segment buffer; entries at or beyond MAX_LEN are tied to zero so the
  // 4-bit read index never leaves the vector.
  logic [15:0][10:0] seg_x_vec;
  logic [15:0][10:0] seg_y_vec;
  logic [15:0]       hit_vec;

  logic        step_tick;
  logic [1:0]  heading_new;
  logic        grow_eff;
  logic [10:0] new_x, new_y;
  logic        wall_hit;
  logic        self_hit;
  logic        collide;
  logic        step_ok;
  logic        do_init;
  logic [4:0]  check_cnt;

  assign step_tick = (state_reg == ST_RUN) && (presc_reg == PRESC_LAST);
  // A request for the exact opposite heading is ignored.
  assign heading_new = (direction == (heading_reg ^ 2'b10)) ? heading_reg : direction;
  // A grow arriving on the step cycle itself still counts for that step.
  assign grow_eff  = grow_pend_reg | grow;
  // Without a grow the tail vacates its cell this step, so it is not a hazard.
  assign check_cnt = grow_eff ? length_reg : (length_reg - 5'd1);
  assign self_hit  = |hit_vec;
  assign collide   = step_tick && (wall_hit || self_hit);
  assign step_ok   = step_tick && !collide;
  assign do_init   = (state_reg == ST_DEAD) && start;

  // Candidate head position for the filtered heading, with edge handling.
  always_comb begin
    new_x    = seg_x_vec[0];
    new_y    = seg_y_vec[0];
    wall_hit = 1'b0;
    case (heading_new)
      2'b00: begin
        if (seg_y_vec[0] == 11'd0) begin
          if (WRAP_EN) new_y = Y_MAX;
          else         wall_hit = 1'b1;
        end else begin
          new_y = seg_y_vec[0] - 11'd1;
        end
      end
      2'b01: begin
        if (seg_x_vec[0] == X_MAX) begin
          if (WRAP_EN) new_x = 11'd0;
          else         wall_hit = 1'b1;
        end else begin
          new_x = seg_x_vec[0] + 11'd1;
        end
      end
      2'b10: begin
        if (seg_y_vec[0] == Y_MAX) begin
          if (WRAP_EN) new_y = 11'd0;
          else         wall_hit = 1'b1;
        end else begin
          new_y = seg_y_vec[0] + 11'd1;
        end
      end
      default: begin
        if (seg_x_vec[0] == 11'd0) begin
          if (WRAP_EN) new_x = X_MAX;
          else         wall_hit = 1'b1;
        end else begin
          new_x = seg_x_vec[0] - 11'd1;
        end
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_seg
      if (gi < MAX_LEN) begin : g_live
        localparam logic [10:0] INIT_X = (gi < 3) ? 11'(GRID_W / 2 - gi) : 11'd0;
        localparam logic [10:0] INIT_Y = (gi < 3) ? Y_CENTER : 11'd0;
        logic [10:0] sx_reg, sy_reg;

        // Segment register: loads the new head (gi=0) or its predecessor on a good step.
        always_ff @(posedge clk) begin
          if (reset || do_init) begin
            sx_reg <= INIT_X;
            sy_reg <= INIT_Y;
          end else if (step_ok) begin
            if (gi == 0) begin
              sx_reg <= new_x;
              sy_reg <= new_y;
            end else begin
              sx_reg <= seg_x_vec[(gi == 0) ? 0 : gi - 1];
              sy_reg <= seg_y_vec[(gi == 0) ? 0 : gi - 1];
            end
          end
        end

        assign seg_x_vec[gi] = sx_reg;
        assign seg_y_vec[gi] = sy_reg;
        assign hit_vec[gi]   = (5'(gi) < check_cnt) &&
                               (seg_x_vec[gi] == new_x) && (seg_y_vec[gi] == new_y);
      end else begin : g_unused
        assign seg_x_vec[gi] = 11'd0;
        assign seg_y_vec[gi] = 11'd0;
        assign hit_vec[gi]   = 1'b0;
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and state-derived outputs.
  always_comb begin
    state_next = state_reg;
    game_over  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (collide) state_next = ST_DEAD;
      end
      ST_DEAD: begin
        game_over = 1'b1;
        if (start) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Prescaler, heading, grow flag, length and step strobe.
  always_ff @(posedge clk) begin
    if (reset || do_init) begin
      presc_reg       <= '0;
      heading_reg     <= HEAD_INIT;
      grow_pend_reg   <= 1'b0;
      length_reg      <= LEN_INIT;
      move_strobe_reg <= 1'b0;
    end else begin
      move_strobe_reg <= step_ok;
      if (state_reg == ST_RUN) begin
        presc_reg <= step_tick ? '0 : presc_reg + 1'b1;
        if (step_tick)  grow_pend_reg <= 1'b0;
        else if (grow)  grow_pend_reg <= 1'b1;
        if (step_ok) begin
          heading_reg <= heading_new;
          if (grow_eff && (length_reg < LEN_MAX)) length_reg <= length_reg + 5'd1;
        end
      end else begin
        presc_reg     <= '0;
        grow_pend_reg <= 1'b0;
      end
    end
  end

  assign head_x      = seg_x_vec[0];
  assign head_y      = seg_y_vec[0];
  assign seg_x       = ({1'b0, seg_sel} < length_reg) ? seg_x_vec[seg_sel] : 11'd0;
  assign seg_y       = ({1'b0, seg_sel} < length_reg) ? seg_y_vec[seg_sel] : 11'd0;
  assign length      = length_reg;
  assign move_strobe = move_strobe_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_snake_motion_engine.sv
// Testbench for snake_motion_engine with MOVE_DIV=4. A behavioural snake
// model predicts each step; predictions are queued and compared against the
// DUT when move_strobe fires.
module tb_snake_motion_engine;
  localparam int GW = 64;
  localparam int GH = 48;
  localparam int MD = 4;
  localparam int ML = 16;

  logic        clk = 1'b0;
  logic        reset, start, grow;
  logic [1:0]  direction;
  logic [3:0]  seg_sel;
  logic [10:0] head_x, head_y, seg_x, seg_y;
  logic [4:0]  length;
  logic        move_strobe, game_over;
  logic [1:0]  state;

  snake_motion_engine #(
    .GRID_W(GW), .GRID_H(GH), .MOVE_DIV(MD), .MAX_LEN(ML)
  ) dut (
    .clk(clk), .reset(reset), .direction(direction), .start(start),
    .grow(grow), .seg_sel(seg_sel), .head_x(head_x), .head_y(head_y),
    .seg_x(seg_x), .seg_y(seg_y), .length(length),
    .move_strobe(move_strobe), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int len;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference snake: index 0 is the head.
  int mx[$];
  int my[$];
  int mlen;
  int mhead;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_init();
    mx = '{32, 31, 30};
    my = '{24, 24, 24};
    mlen  = 3;
    mhead = 1;
    sb_q.delete();
  endtask

  task automatic model_step(input int dir, input bit g, output bit hit);
    int nh, nx, ny, lim;
    nh  = (dir == (mhead ^ 2)) ? mhead : dir;
    nx  = mx[0];
    ny  = my[0];
    hit = 1'b0;
    case (nh)
      0:       ny = ny - 1;
      1:       nx = nx + 1;
      2:       ny = ny + 1;
      default: nx = nx - 1;
    endcase
`ifdef SNAKE_WRAP_EN
    if (nx < 0)   nx = GW - 1;
    if (nx >= GW) nx = 0;
    if (ny < 0)   ny = GH - 1;
    if (ny >= GH) ny = 0;
`else
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) hit = 1'b1;
`endif
    lim = g ? mlen : mlen - 1;
    for (int i = 0; i < lim; i++)
      if (mx[i] == nx && my[i] == ny) hit = 1'b1;
    if (!hit) begin
      mhead = nh;
      mx.push_front(nx);
      my.push_front(ny);
      if (g && mlen < ML) mlen++;
      while (mx.size() > mlen) begin
        void'(mx.pop_back());
        void'(my.pop_back());
      end
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_init();
    seg_sel = 4'd1;
    #1;
    $display("reset %s: state=%0d head=(%0d,%0d) len=%0d", tag, state, head_x, head_y, length);
    check_val({tag, "_state"},  state, 0);
    check_val({tag, "_hx"},     head_x, 32);
    check_val({tag, "_hy"},     head_y, 24);
    check_val({tag, "_s1x"},    seg_x, 31);
    check_val({tag, "_s1y"},    seg_y, 24);
    check_val({tag, "_len"},    length, 3);
    check_val({tag, "_strobe"}, move_strobe, 0);
    check_val({tag, "_over"},   game_over, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One snake step: predict, wait (bounded) for move_strobe, compare.
  // grow_at selects which clock edge of the 4-cycle interval carries a grow pulse.
  task automatic do_step(input string tag, input int dir, input int grow_at);
    bit   hit, seen;
    int   n, px, py;
    exp_t e;
    direction = 2'(dir);
    px = head_x;
    py = head_y;
    model_step(dir, grow_at != 0, hit);
    if (!hit) begin
      e.x = mx[0]; e.y = my[0]; e.len = mlen;
      sb_q.push_back(e);
    end
    seen = 1'b0;
    n = 0;
    while (!seen && n < 12) begin
      n++;
      grow = (n == grow_at);
      @(negedge clk);
      if (move_strobe) seen = 1'b1;
    end
    grow = 1'b0;
    if (hit) begin
      $display("step %s dir=%0d: collision expected, strobe=%0d state=%0d head=(%0d,%0d)",
               tag, dir, seen, state, head_x, head_y);
      check_val({tag, "_nostrobe"}, seen, 0);
      check_val({tag, "_dstate"},   state, 2);
      check_val({tag, "_over"},     game_over, 1);
      check_val({tag, "_hx_hold"},  head_x, px);
      check_val({tag, "_hy_hold"},  head_y, py);
    end else begin
      check_val({tag, "_strobe"}, seen, 1);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      if (seen) begin
        check_val({tag, "_gap"}, n, MD);
        check_val({tag, "_hx"},  head_x, e.x);
        check_val({tag, "_hy"},  head_y, e.y);
        check_val({tag, "_len"}, length, e.len);
        seg_sel = 4'd1;
        #1;
        check_val({tag, "_s1x"}, seg_x, mx[1]);
        check_val({tag, "_s1y"}, seg_y, my[1]);
        seg_sel = 4'(mlen - 1);
        #1;
        check_val({tag, "_tailx"}, seg_x, mx[mlen-1]);
        if (mlen < 16) begin
          seg_sel = 4'(mlen);
          #1;
          check_val({tag, "_beyond"}, seg_x + seg_y, 0);
        end
      end
      $display("step %s dir=%0d: head=(%0d,%0d) len=%0d exp=(%0d,%0d) len=%0d",
               tag, dir, head_x, head_y, length, e.x, e.y, e.len);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; grow = 1'b0; direction = 2'b01; seg_sel = 4'd0;
    @(negedge clk);
    do_reset("rst0");

    // Straight run right: 4 steps to (36,24)
    do_start();
    for (int i = 0; i < 4; i++) do_step("right", 1, 0);
    check_val("run_state", state, 1);

    // Reversal request ignored
    for (int i = 0; i < 2; i++) do_step("rev", 3, 0);

    // Reset landing exactly on a step edge wins
    direction = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("rststep_strobe", move_strobe, 0);
    do_reset("rst_step");

    // Up to the top wall
    do_start();
    for (int i = 0; i < 25; i++) do_step("up", 0, 0);
`ifdef SNAKE_WRAP_EN
    check_val("wrap_state", state, 1);
`else
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_val("restart_state", state, 0);
    check_val("restart_hy", head_y, 24);
    check_val("restart_len", length, 3);
    check_val("restart_over", game_over, 0);
`endif
    do_reset("rst_wall");

    // Grow ignored in IDLE, coincident grow, then saturation at MAX_LEN
    grow = 1'b1;
    @(negedge clk);
    grow = 1'b0;
    do_start();
    do_step("g_idle", 1, 0);
    do_step("g_coinc", 1, 4);
    for (int i = 0; i < 12; i++) do_step("g_up", 1, 1);
    do_step("g_sat", 1, 2);
    @(negedge clk);
    check_val("strobe_width", move_strobe, 0);
    do_reset("rst_grow");

    // Length 5 box turn bites the body
    do_start();
    do_step("l5_g1", 1, 1);
    do_step("l5_g2", 1, 1);
    do_step("l5_up", 0, 0);
    do_step("l5_left", 3, 0);
    do_step("l5_down", 2, 0);
    do_reset("rst_l5");

    // Length 4 same turn: tail vacates just in time
    do_start();
    do_step("l4_g1", 1, 1);
    do_step("l4_up", 0, 0);
    do_step("l4_left", 3, 0);
    do_step("l4_down", 2, 0);
    check_val("l4_state", state, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
